// File: rtl/sl_arb_if.sv
`default_nettype none
// ============================================================================
// sl_arb_if : request/grant bundle between bus units and the slave-bus arbiter
// Rev 1.0
// ============================================================================
interface sl_arb_if #(
  parameter int NUM_DEV = 7,
  parameter int IDW     = 3
);
  logic [NUM_DEV-1:0] sl_arb_request;
  logic [NUM_DEV-1:0] prio_mask;
  logic [NUM_DEV-1:0] sl_arb_grant;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;
  logic               bus_idle;
  logic               timeout_err;
  logic [IDW-1:0]     timeout_id;

  modport master (
    output sl_arb_request, prio_mask,
    input  sl_arb_grant, grant_valid, grant_id, bus_idle, timeout_err, timeout_id
  );

  modport slave (
    input  sl_arb_request, prio_mask,
    output sl_arb_grant, grant_valid, grant_id, bus_idle, timeout_err, timeout_id
  );
endinterface
`default_nettype wire

// File: rtl/sl_arb_sched.sv
`default_nettype none
// ============================================================================
// sl_arb_sched : fixed-priority + round-robin arbiter for the shared slave bus,
//                with a hold watchdog that revokes and blocks stuck units.
// Rev 1.0
// ============================================================================
module sl_arb_sched #(
  parameter int NUM_DEV = 7,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 65535,
  parameter int CW      = 16
) (
  input wire      clk,
  input wire      reset,
  sl_arb_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [IDW-1:0] RR_RESET  = IDW'(NUM_DEV - 1);
  localparam logic [CW-1:0]  HOLD_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam bit             WDOG_EN   = (TIMEOUT != 0);

  state_t             state_q, state_d;
  logic [NUM_DEV-1:0] grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic               bus_idle_q, bus_idle_d;
  logic               timeout_err_q, timeout_err_d;
  logic [IDW-1:0]     timeout_id_q, timeout_id_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic               owner_prio_q, owner_prio_d;
  logic [CW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [NUM_DEV-1:0] blocked_q, blocked_d;

  logic [NUM_DEV-1:0] elig;
  logic [NUM_DEV-1:0] elig_prio;
  logic [IDW-1:0]     prio_winner;
  logic [IDW-1:0]     rr_winner;
  logic [IDW-1:0]     winner;
  logic               owner_req;

  function automatic logic [IDW-1:0] lowest_set(input logic [NUM_DEV-1:0] vec);
    logic [IDW-1:0]     idx;
    logic [NUM_DEV-1:0] sh;
    idx = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      sh = vec >> i;
      if (sh[0]) idx = IDW'(i);
    end
    return idx;
  endfunction

  // Scan downward in distance so the unit closest after ptr wins.
  function automatic logic [IDW-1:0] rr_next(input logic [NUM_DEV-1:0] vec,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW-1:0]     idx;
    logic [NUM_DEV-1:0] sh;
    int                 pos;
    idx = '0;
    for (int k = NUM_DEV; k >= 1; k--) begin
      pos = (int'(ptr) + k) % NUM_DEV;
      sh  = vec >> pos;
      if (sh[0]) idx = IDW'(pos);
    end
    return idx;
  endfunction

  assign elig        = bus.sl_arb_request & ~blocked_q;
  assign elig_prio   = elig & bus.prio_mask;
  assign prio_winner = lowest_set(elig_prio);
  assign rr_winner   = rr_next(elig, rr_ptr_q);
  assign winner      = (|elig_prio) ? prio_winner : rr_winner;
  assign owner_req   = |(bus.sl_arb_request & grant_q);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    timeout_err_d = 1'b0;
    timeout_id_d  = timeout_id_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    owner_prio_d  = owner_prio_q;
    hold_cnt_d    = hold_cnt_q;
    // A blocked unit is released as soon as it lets go of its request.
    blocked_d     = blocked_q & bus.sl_arb_request;

    unique case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d      = ST_GRANT;
          grant_d      = NUM_DEV'(1) << winner;
          grant_id_d   = winner;
          owner_d      = winner;
          owner_prio_d = |elig_prio;
          hold_cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + 1'b1;
        if (!owner_req) begin
          state_d    = ST_GAP;
          grant_d    = '0;
          grant_id_d = '0;
        end else if (WDOG_EN && (hold_cnt_q == HOLD_LAST)) begin
          state_d       = ST_GAP;
          grant_d       = '0;
          grant_id_d    = '0;
          timeout_err_d = 1'b1;
          timeout_id_d  = owner_q;
          blocked_d     = blocked_d | grant_q;
        end
      end
      ST_GAP: begin
        // Priority wins do not advance the fairness pointer.
        if (!owner_prio_q) rr_ptr_d = owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
      end
    endcase

    grant_valid_d = |grant_d;
    bus_idle_d    = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      bus_idle_q    <= 1'b1;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
      rr_ptr_q      <= RR_RESET;
      owner_q       <= '0;
      owner_prio_q  <= 1'b0;
      hold_cnt_q    <= '0;
      blocked_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      bus_idle_q    <= bus_idle_d;
      timeout_err_q <= timeout_err_d;
      timeout_id_q  <= timeout_id_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      owner_prio_q  <= owner_prio_d;
      hold_cnt_q    <= hold_cnt_d;
      blocked_q     <= blocked_d;
    end
  end

  assign bus.sl_arb_grant = grant_q;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.bus_idle     = bus_idle_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.timeout_id   = timeout_id_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(grant_q));

  a_valid_matches: assert property (@(posedge clk) disable iff (!reset)
    grant_valid_q == (|grant_q));

  a_winner_requests: assert property (@(posedge clk) disable iff (!reset)
    (state_q == ST_IDLE && (|elig)) |-> bus.sl_arb_request[winner]);

endmodule
`default_nettype wire

// File: tb/tb_sl_arb_sched.sv
`default_nettype none
// ============================================================================
// tb_sl_arb_sched : directed vector table, corner sequences and randomized
//                   traffic against a cycle-level reference model.
// Rev 1.0
// ============================================================================
module tb_sl_arb_sched;

  localparam int N   = 7;
  localparam int IDW = 3;
  localparam int TO  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sl_arb_if #(.NUM_DEV(N), .IDW(IDW)) bus ();

  sl_arb_sched #(.NUM_DEV(N), .IDW(IDW), .TIMEOUT(TO), .CW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0]   req;
    logic [N-1:0]   prio;
    logic [N-1:0]   grant;
    logic [IDW-1:0] id;
    logic           idle;
    logic           terr;
    logic [IDW-1:0] tid;
    int             n;
  } vec_t;

  vec_t tbl[$];
  int   rr_order[6] = '{1, 4, 6, 1, 4, 6};

  // Reference model: who owns the bus, how long it has held it, and the
  // bookkeeping needed to pick the next owner.
  int         m_owner, m_done, m_held, m_rr, m_tid;
  bit         m_gap, m_prio, m_terr;
  bit [N-1:0] m_blk;

  function automatic bit bit_at(input bit [N-1:0] v, input int i);
    bit [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_done = 0; m_held = 0; m_rr = N - 1; m_tid = 0;
    m_gap = 0; m_prio = 0; m_terr = 0; m_blk = '0;
  endfunction

  function automatic void model_step(input bit [N-1:0] req, input bit [N-1:0] prio);
    bit [N-1:0] nb;
    bit [N-1:0] elig;
    int         w;
    nb     = m_blk & req;
    m_terr = 0;
    if (m_owner >= 0) begin
      m_held++;
      if (!bit_at(req, m_owner)) begin
        m_done = m_owner; m_owner = -1; m_gap = 1;
      end else if (m_held == TO) begin
        m_terr = 1; m_tid = m_owner; nb = nb | (N'(1) << m_owner);
        m_done = m_owner; m_owner = -1; m_gap = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
      if (!m_prio) m_rr = m_done;
    end else begin
      elig = req & ~m_blk;
      w    = -1;
      for (int i = 0; i < N; i++)
        if (w < 0 && bit_at(elig, i) && bit_at(prio, i)) w = i;
      m_prio = (w >= 0);
      for (int k = 1; k <= N; k++)
        if (w < 0 && bit_at(elig, (m_rr + k) % N)) w = (m_rr + k) % N;
      if (w >= 0) begin
        m_owner = w; m_held = 0;
      end
    end
    m_blk = nb;
  endfunction

  function automatic logic [15:0] pack(input logic [N-1:0] g, input logic [IDW-1:0] id,
                                       input logic idle, input logic terr,
                                       input logic [IDW-1:0] tid);
    return {g, id, |g, idle, terr, tid};
  endfunction

  function automatic logic [15:0] model_out();
    logic [N-1:0]   g;
    logic [IDW-1:0] id;
    g  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    id = (m_owner >= 0) ? IDW'(m_owner) : '0;
    return pack(g, id, (m_owner < 0) && !m_gap, m_terr, IDW'(m_tid));
  endfunction

  function automatic void add(input logic [N-1:0] req, input logic [N-1:0] prio,
                              input logic [N-1:0] grant, input int id, input bit idle,
                              input bit terr, input int tid, input int n);
    vec_t v;
    v.req = req; v.prio = prio; v.grant = grant; v.id = IDW'(id);
    v.idle = idle; v.terr = terr; v.tid = IDW'(tid); v.n = n;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {bus.sl_arb_grant, bus.grant_id, bus.grant_valid, bus.bus_idle,
           bus.timeout_err, bus.timeout_id};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got grant=%b id=%0d valid=%b idle=%b terr=%b tid=%0d, expected grant=%b id=%0d valid=%b idle=%b terr=%b tid=%0d",
               name, act[15:9], act[8:6], act[5], act[4], act[3], act[2:0],
               exp[15:9], exp[8:6], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] p);
    bus.sl_arb_request = r;
    bus.prio_mask      = p;
    @(posedge clk);
    model_step(r, p);
    #1;
  endtask

  initial begin
    int         got;
    int         dead;
    logic [N-1:0] rq;
    logic [N-1:0] rp;

    bus.sl_arb_request = '0;
    bus.prio_mask      = '0;

    //   req         prio        grant       id idle terr tid n
    add(7'b0000100, 7'b0000000, 7'b0000100, 2, 0, 0, 0, 4);
    add(7'b0000000, 7'b0000000, 7'b0000000, 0, 0, 0, 0, 1);
    add(7'b0000000, 7'b0000000, 7'b0000000, 0, 1, 0, 0, 1);
    add(7'b0100011, 7'b0000001, 7'b0000001, 0, 0, 0, 0, 2);
    add(7'b0100010, 7'b0000001, 7'b0000000, 0, 0, 0, 0, 1);
    add(7'b0100010, 7'b0000001, 7'b0000000, 0, 1, 0, 0, 1);
    add(7'b0100010, 7'b0000001, 7'b0100000, 5, 0, 0, 0, 2);
    add(7'b0000010, 7'b0000000, 7'b0000000, 0, 0, 0, 0, 1);
    add(7'b0000010, 7'b0000000, 7'b0000000, 0, 1, 0, 0, 1);
    add(7'b0001010, 7'b0000000, 7'b0000010, 1, 0, 0, 0, 1);
    add(7'b0001000, 7'b0000000, 7'b0000000, 0, 0, 0, 0, 1);
    add(7'b0000000, 7'b0000000, 7'b0000000, 0, 1, 0, 0, 1);
    add(7'b0011000, 7'b0000000, 7'b0001000, 3, 0, 0, 0, 8);
    add(7'b0011000, 7'b0000000, 7'b0000000, 0, 0, 1, 3, 1);
    add(7'b0011000, 7'b0000000, 7'b0000000, 0, 1, 0, 3, 1);
    add(7'b0011000, 7'b0000000, 7'b0010000, 4, 0, 0, 3, 1);
    add(7'b0001000, 7'b0000000, 7'b0000000, 0, 0, 0, 3, 1);
    add(7'b0001000, 7'b0000000, 7'b0000000, 0, 1, 0, 3, 2);
    add(7'b0000000, 7'b0000000, 7'b0000000, 0, 1, 0, 3, 1);
    add(7'b0001000, 7'b0000000, 7'b0001000, 3, 0, 0, 3, 8);
    add(7'b0000000, 7'b0000000, 7'b0000000, 0, 0, 0, 3, 1);
    add(7'b0000000, 7'b0000000, 7'b0000000, 0, 1, 0, 3, 1);
    add(7'b0001000, 7'b0000000, 7'b0001000, 3, 0, 0, 3, 1);
    add(7'b0000000, 7'b0000000, 7'b0000000, 0, 0, 0, 3, 1);
    add(7'b0000000, 7'b0000000, 7'b0000000, 0, 1, 0, 3, 1);

    #1 reset = 1'b0;
    model_reset();
    #1 check("reset_state", pack('0, '0, 1'b1, 1'b0, '0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].n; r++) begin
        cycle(tbl[i].req, tbl[i].prio);
        check($sformatf("vec%0d.%0d", i, r),
              pack(tbl[i].grant, tbl[i].id, tbl[i].idle, tbl[i].terr, tbl[i].tid));
      end
    end

    // Reset dropped in the middle of a grant clears outputs with no clock edge.
    cycle(7'b0100000, '0);
    check("pre_rst_grant", pack(7'b0100000, 3'd5, 1'b0, 1'b0, 3'd3));
    #2 reset = 1'b0;
    model_reset();
    #1 check("async_rst", pack('0, '0, 1'b1, 1'b0, '0));
    @(negedge clk);
    reset = 1'b1;
    cycle(7'b0100001, '0);
    check("post_rst_rr", pack(7'b0000001, 3'd0, 1'b0, 1'b0, '0));
    cycle('0, '0);
    cycle('0, '0);
    check("post_rst_idle", pack('0, '0, 1'b1, 1'b0, '0));

    // Round-robin rotation with each winner releasing after three cycles.
    dead = 0;
    for (int g = 0; g < 6; g++) begin
      got = -1;
      for (int c = 0; c < 6 && got < 0; c++) begin
        cycle(7'b1010010, '0);
        if (bus.grant_valid) got = int'(bus.grant_id);
        else dead++;
      end
      checks++;
      if (got != rr_order[g] || (g > 0 && dead != 2)) begin
        failures++;
        $display("FAIL rr_order%0d: got unit %0d after %0d dead cycles, expected unit %0d after 2",
                 g, got, dead, rr_order[g]);
      end
      dead = 0;
      repeat (2) cycle(7'b1010010, '0);
      cycle(7'b1010010 & ~(N'(1) << got), '0);
      if (!bus.grant_valid) dead++;
    end

    // Randomized traffic against the reference model.
    bus.sl_arb_request = '0;
    bus.prio_mask      = '0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    rq = '0;
    rp = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 10) rq = rq ^ (N'(1) << i);
      if ($urandom_range(0, 39) == 0)
        rp = N'($urandom_range(0, 127)) & N'($urandom_range(0, 127));
      cycle(rq, rp);
      check($sformatf("rand%0d", t), model_out());
      checks++;
      if (!$onehot0(bus.sl_arb_grant)) begin
        failures++;
        $display("FAIL onehot%0d: got grant=%b, expected at most one bit set", t, bus.sl_arb_grant);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sl_arb_sched.md
Name: sl_arb_sched

Overview:
- Arbiter and scheduler for the shared slave output bus (sl_data/sl_addr/sl_tail/sl_latch_tail) driven by the bus interface units: basics, MBus ×2, GOC, GPIO, PMU and EIN.
- Accepts one request line per unit and issues a one-hot grant.
- Mixes fixed-priority override with round-robin fairness.
- Revokes a grant held past a watchdog limit and reports the offender.

Parameters:
- NUM_DEV, 7, number of requesters; bit i of every vector belongs to unit i.
- IDW, 3, width of grant_id/timeout_id; must satisfy 2^IDW >= NUM_DEV.
- TIMEOUT, 65535, maximum grant hold in cycles; 0 disables the watchdog.
- CW, 16, width of the hold counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- reset, input, 1, asynchronous active-low reset.
- sl_arb_request, input, NUM_DEV, level request per unit; held high for the whole frame.
- prio_mask, input, NUM_DEV, 1 = unit is high priority (served before round-robin units).
- sl_arb_grant, output, NUM_DEV, registered one-hot grant (all-zero when idle).
- grant_valid, output, 1, OR of sl_arb_grant.
- grant_id, output, IDW, index of granted unit; 0 when idle.
- bus_idle, output, 1, high in state IDLE.
- timeout_err, output, 1, one-cycle pulse when a grant is revoked.
- timeout_id, output, IDW, index of last revoked unit; holds until next revoke.

Behaviour:
- Reset (reset low, async):
  - state=IDLE, sl_arb_grant=0, grant_valid=0, grant_id=0.
  - bus_idle=1, timeout_err=0, timeout_id=0.
  - rr_ptr=NUM_DEV-1, hold_cnt=0, blocked=0.
  - Deassertion is sampled synchronously by clk.
- Eligible vector: elig = sl_arb_request & ~blocked.
- Winner selection (combinational, evaluated in IDLE only):
  - If (elig & prio_mask) != 0: winner = lowest index set in it.
  - Else: winner = first set bit of elig searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_DEV.
- States:
  - IDLE:
    - If elig != 0: next cycle state=GRANT, sl_arb_grant=1<<winner, grant_id=winner, hold_cnt=0.
    - Request-to-grant latency = 1 clk.
  - GRANT:
    - Grant is frozen; other requests and prio_mask changes are ignored.
    - hold_cnt increments each cycle, saturating at 2^CW-1.
    - If sl_arb_request[grant_id]==0: next state=GAP, grant cleared.
    - Else if TIMEOUT!=0 and hold_cnt==TIMEOUT-1: next state=GAP, grant cleared, timeout_err=1 for that one cycle, timeout_id=grant_id, blocked[grant_id] set.
    - Request drop takes precedence over timeout in the same cycle (no error raised).
    - When a grant is held without release, the revoke takes effect after exactly TIMEOUT cycles of grant.
  - GAP:
    - Exactly one cycle with grant=0 (bus turnaround, lets the unit release sl_ lines).
    - rr_ptr=grant_id is updated only if the completed grant was a round-robin (non-priority) win.
    - Next state=IDLE.
- Minimum dead time between consecutive grants: GAP + IDLE = 2 cycles.
- blocked[i] clears in any cycle where sl_arb_request[i]==0. A blocked unit is re-eligible only after dropping and re-raising its request.
- Simultaneous events:
  - Request rising in the same cycle as another's release is arbitrated in the following IDLE.
  - Only the current grant_id's request is watched in GRANT.
  - If the granted unit's request drops and re-rises within GRANT, the drop is observed and GAP is entered.
- Request of an unblocked unit asserted then dropped while another unit holds the grant is never granted (level semantics, no latching).
- Reset asserted mid-grant: grant clears immediately (async); no timeout_err is generated.
- Invariants:
  - sl_arb_grant is never more than one-hot.
  - Grant never goes to a unit whose request is low at the IDLE decision cycle.

Test Plan:
- Single request: after reset, raise req[2] at cycle 0 → grant=0000100 at cycle 1, grant_id=2. Drop req at cycle 5 → grant=0 at cycle 6 (GAP), bus_idle=1 at cycle 7.
- Round-robin fairness: req[1], req[4], req[6] held, each dropped 3 cycles after grant then re-raised, prio_mask=0 → grant order 1,4,6,1,4,6, with 2 dead cycles between grants.
- Priority override: prio_mask=0000001, req[0] and req[5] raised together → unit 0 granted first. On release, unit 5 is granted and rr_ptr stays unchanged until unit 5's grant completes (then rr_ptr=5).
- Watchdog: TIMEOUT=8, req[3] held forever → grant drops after 8 granted cycles, timeout_err pulses once, timeout_id=3. Unit 3 is not regranted until req[3] goes low then high. Other pending requester is granted after the GAP+IDLE.
- Release/timeout collision: TIMEOUT=8, req[3] dropped in the same cycle hold_cnt==7 → no timeout_err, blocked[3]=0.
- Async reset mid-grant: assert reset low while grant=0100000 → grant=0, bus_idle=1 with no clock edge. After release, the first requester is arbitrated from rr_ptr=NUM_DEV-1 (unit 0 wins among equals).
